// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM decode stage with condition check, control decode,
// write-through register file, RAW hazard detection against EXE/MEM and a
// registered ID/EX boundary (valid / stall / flush).
//
// Ports:
//   clk, rst (async active-low)
//   pc_in, instr_in, in_valid  - instruction currently in ID
//   status                     - {Z,C,N,V}
//   wb_en/wb_dest/wb_value     - register-file write port
//   exe_wb_en/exe_dest         - EXE-stage pending writer
//   mem_wb_en/mem_dest         - MEM-stage pending writer
//   stall, flush               - ID/EX hold / kill
//   hazard                     - combinational RAW hazard (freeze PC, IF/ID)
//   ex_*                       - registered ID/EX contents
module id_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 16,
  parameter bit HAZ_MEM_EN = 1'b1,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instr_in,
  input  logic              in_valid,
  input  logic [3:0]        status,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic [ADDR_W-1:0] exe_dest,
  input  logic              mem_wb_en,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic              stall,
  input  logic              flush,
  output logic              hazard,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic              ex_imm,
  output logic [3:0]        ex_exe_cmd,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [11:0]       ex_shift_op,
  output logic [23:0]       ex_imm24,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [ADDR_W-1:0] ex_src1,
  output logic [ADDR_W-1:0] ex_src2
);

  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic       b;
    logic       s;
    logic [3:0] cmd;
  } ctrl_t;

  logic [1:0]        w_mode;
  logic [3:0]        w_op, w_cond;
  logic              w_i, w_s;
  logic              w_z, w_c, w_n, w_v;
  logic              w_cond_ok;
  logic              w_str, w_mov_mvn, w_branch;
  logic              w_use1, w_use2, w_hit1, w_hit2;
  logic [ADDR_W-1:0] w_src1, w_src2, w_dest;
  logic [DATA_W-1:0] w_val_rn, w_val_rm;
  ctrl_t             w_dec, w_ctrl;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  ctrl_t             r_ctrl;
  logic              r_valid, r_imm;
  logic [DATA_W-1:0] r_pc, r_val_rn, r_val_rm;
  logic [11:0]       r_shift_op;
  logic [23:0]       r_imm24;
  logic [ADDR_W-1:0] r_dest, r_src1, r_src2;

  assign w_cond = instr_in[31:28];
  assign w_mode = instr_in[27:26];
  assign w_i    = instr_in[25];
  assign w_op   = instr_in[24:21];
  assign w_s    = instr_in[20];
  assign {w_z, w_c, w_n, w_v} = status;

  always_comb begin
    case (w_cond)
      4'h0:    w_cond_ok = w_z;
      4'h1:    w_cond_ok = !w_z;
      4'h2:    w_cond_ok = w_c;
      4'h3:    w_cond_ok = !w_c;
      4'h4:    w_cond_ok = w_n;
      4'h5:    w_cond_ok = !w_n;
      4'h6:    w_cond_ok = w_v;
      4'h7:    w_cond_ok = !w_v;
      4'h8:    w_cond_ok = w_c && !w_z;
      4'h9:    w_cond_ok = !w_c || w_z;
      4'hA:    w_cond_ok = (w_n == w_v);
      4'hB:    w_cond_ok = (w_n != w_v);
      4'hC:    w_cond_ok = !w_z && (w_n == w_v);
      4'hD:    w_cond_ok = w_z || (w_n != w_v);
      default: w_cond_ok = 1'b1;  // AL and 1111
    endcase
  end

  always_comb begin
    w_dec = '0;
    case (w_mode)
      2'b00: begin
        w_dec.s     = w_s;
        w_dec.wb_en = 1'b1;
        case (w_op)
          4'b1101: w_dec.cmd = 4'b0001;  // MOV
          4'b1111: w_dec.cmd = 4'b1001;  // MVN
          4'b0100: w_dec.cmd = 4'b0010;  // ADD
          4'b0101: w_dec.cmd = 4'b0011;  // ADC
          4'b0010: w_dec.cmd = 4'b0100;  // SUB
          4'b0110: w_dec.cmd = 4'b0101;  // SBC
          4'b0000: w_dec.cmd = 4'b0110;  // AND
          4'b1100: w_dec.cmd = 4'b0111;  // ORR
          4'b0001: w_dec.cmd = 4'b1000;  // EOR
          4'b1010: begin w_dec.cmd = 4'b0100; w_dec.wb_en = 1'b0; end  // CMP
          4'b1000: begin w_dec.cmd = 4'b0110; w_dec.wb_en = 1'b0; end  // TST
          default: w_dec.wb_en = 1'b0;
        endcase
      end
      2'b01: begin
        w_dec.cmd = 4'b0010;  // address = base + offset
        if (w_s) begin
          w_dec.mem_r = 1'b1;
          w_dec.wb_en = 1'b1;
        end else begin
          w_dec.mem_w = 1'b1;
        end
      end
      2'b10:   w_dec.b = 1'b1;
      default: ;
    endcase
  end

  // Failed condition still travels as a valid instruction, just with no effect.
  assign w_ctrl = (w_cond_ok && in_valid) ? w_dec : '0;

  assign w_str     = (w_mode == 2'b01) && !w_s;
  assign w_mov_mvn = (w_mode == 2'b00) && ((w_op == 4'b1101) || (w_op == 4'b1111));
  assign w_branch  = (w_mode == 2'b10);

  // STR reads its data register (Rd field) through the second port.
  assign w_src1 = instr_in[16 +: ADDR_W];
  assign w_src2 = w_str ? instr_in[12 +: ADDR_W] : instr_in[0 +: ADDR_W];
  assign w_dest = instr_in[12 +: ADDR_W];

  assign w_val_rn = (wb_en && (wb_dest == w_src1)) ? wb_value : r_regs[w_src1];
  assign w_val_rm = (wb_en && (wb_dest == w_src2)) ? wb_value : r_regs[w_src2];

  assign w_use1 = in_valid && !(w_mov_mvn || w_branch);
  assign w_use2 = in_valid && (((w_mode == 2'b00) && !w_i) || w_str);

  assign w_hit1 = (exe_wb_en && (exe_dest == w_src1)) ||
                  (HAZ_MEM_EN && mem_wb_en && (mem_dest == w_src1));
  assign w_hit2 = (exe_wb_en && (exe_dest == w_src2)) ||
                  (HAZ_MEM_EN && mem_wb_en && (mem_dest == w_src2));

  assign hazard = (w_use1 && w_hit1) || (w_use2 && w_hit2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (wb_en) begin
      r_regs[wb_dest] <= wb_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_imm      <= 1'b0;
      r_pc       <= '0;
      r_val_rn   <= '0;
      r_val_rm   <= '0;
      r_shift_op <= '0;
      r_imm24    <= '0;
      r_dest     <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
    end else begin
      // Data fields follow the bubble and normal cases alike; only stall holds.
      if (flush || !stall) begin
        r_imm      <= w_i;
        r_pc       <= pc_in;
        r_val_rn   <= w_val_rn;
        r_val_rm   <= w_val_rm;
        r_shift_op <= instr_in[11:0];
        r_imm24    <= instr_in[23:0];
        r_dest     <= w_dest;
        r_src1     <= w_src1;
        r_src2     <= w_src2;
      end
      if (flush || (!stall && hazard)) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else if (!stall) begin
        r_valid <= in_valid;
        r_ctrl  <= w_ctrl;
      end
    end
  end

  assign ex_valid    = r_valid;
  assign ex_wb_en    = r_ctrl.wb_en;
  assign ex_mem_r_en = r_ctrl.mem_r;
  assign ex_mem_w_en = r_ctrl.mem_w;
  assign ex_b        = r_ctrl.b;
  assign ex_s        = r_ctrl.s;
  assign ex_exe_cmd  = r_ctrl.cmd;
  assign ex_imm      = r_imm;
  assign ex_pc       = r_pc;
  assign ex_val_rn   = r_val_rn;
  assign ex_val_rm   = r_val_rm;
  assign ex_shift_op = r_shift_op;
  assign ex_imm24    = r_imm24;
  assign ex_dest     = r_dest;
  assign ex_src1     = r_src1;
  assign ex_src2     = r_src2;

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  logic        clk, rst;
  logic [31:0] pc_in, instr, wb_value;
  logic        in_valid, wb_en, exe_wb_en, mem_wb_en, stall, flush;
  logic [3:0]  status, wb_dest, exe_dest, mem_dest;

  logic        hazard, ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
  logic [3:0]  ex_exe_cmd, ex_dest, ex_src1, ex_src2;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_op;
  logic [23:0] ex_imm24;

  logic        d2_hazard, d2_valid, d2_wb_en, d2_mem_r_en, d2_mem_w_en, d2_b, d2_s, d2_imm;
  logic [3:0]  d2_cmd;
  logic [15:0] d2_pc, d2_val_rn, d2_val_rm;
  logic [11:0] d2_shift_op;
  logic [23:0] d2_imm24;
  logic [2:0]  d2_dest, d2_src1, d2_src2;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr), .in_valid(in_valid),
    .status(status), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .stall(stall), .flush(flush), .hazard(hazard), .ex_valid(ex_valid),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm), .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc),
    .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_shift_op(ex_shift_op),
    .ex_imm24(ex_imm24), .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
  );

  id_stage_pipe #(.DATA_W(16), .NUM_REGS(8), .HAZ_MEM_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .pc_in(pc_in[15:0]), .instr_in(instr), .in_valid(in_valid),
    .status(status), .wb_en(wb_en), .wb_dest(wb_dest[2:0]), .wb_value(wb_value[15:0]),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest[2:0]), .mem_wb_en(mem_wb_en),
    .mem_dest(mem_dest[2:0]), .stall(stall), .flush(flush), .hazard(d2_hazard),
    .ex_valid(d2_valid), .ex_wb_en(d2_wb_en), .ex_mem_r_en(d2_mem_r_en),
    .ex_mem_w_en(d2_mem_w_en), .ex_b(d2_b), .ex_s(d2_s), .ex_imm(d2_imm),
    .ex_exe_cmd(d2_cmd), .ex_pc(d2_pc), .ex_val_rn(d2_val_rn), .ex_val_rm(d2_val_rm),
    .ex_shift_op(d2_shift_op), .ex_imm24(d2_imm24), .ex_dest(d2_dest),
    .ex_src1(d2_src1), .ex_src2(d2_src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit        valid, wb, mr, mw, b, s, imm;
    bit [3:0]  cmd;
    bit [31:0] pc, rn, rm;
    bit [11:0] sh;
    bit [23:0] i24;
    bit [3:0]  dest, s1, s2;
  } ex_t;

  bit [31:0] m_regs [16];
  ex_t       m_ex;

  // Conditions come in complementary pairs: odd code = negated even code.
  function automatic bit cond_pass(bit [3:0] c, bit [3:0] st);
    bit z, cf, n, v, base;
    {z, cf, n, v} = st;
    if (c == 4'hF) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic bit [31:0] rd(bit [3:0] a);
    return (wb_en && wb_dest == a) ? wb_value : m_regs[a];
  endfunction

  function automatic bit pend(bit [3:0] a);
    return (exe_wb_en && exe_dest == a) || (mem_wb_en && mem_dest == a);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("ex_valid", ex_valid, m_ex.valid);
    chk("ex_wb_en", ex_wb_en, m_ex.wb);
    chk("ex_mem_r_en", ex_mem_r_en, m_ex.mr);
    chk("ex_mem_w_en", ex_mem_w_en, m_ex.mw);
    chk("ex_b", ex_b, m_ex.b);
    chk("ex_s", ex_s, m_ex.s);
    chk("ex_exe_cmd", ex_exe_cmd, m_ex.cmd);
    if (m_ex.valid) begin
      chk("ex_imm", ex_imm, m_ex.imm);
      chk("ex_pc", ex_pc, m_ex.pc);
      chk("ex_val_rn", ex_val_rn, m_ex.rn);
      chk("ex_val_rm", ex_val_rm, m_ex.rm);
      chk("ex_shift_op", ex_shift_op, m_ex.sh);
      chk("ex_imm24", ex_imm24, m_ex.i24);
      chk("ex_dest", ex_dest, m_ex.dest);
      chk("ex_src1", ex_src1, m_ex.s1);
      chk("ex_src2", ex_src2, m_ex.s2);
    end
  endtask

  // One clock with the current inputs: check hazard, advance model, check ex_*.
  task automatic cycle();
    ex_t d;
    bit [1:0] mode;
    bit [3:0] op;
    bit sb, str, hz;
    #1;
    mode = instr[27:26];
    op   = instr[24:21];
    sb   = instr[20];
    str  = (mode == 2'd1) && !sb;
    d = '{default: 0};
    d.valid = in_valid;
    d.pc    = pc_in;
    d.imm   = instr[25];
    d.sh    = instr[11:0];
    d.i24   = instr[23:0];
    d.dest  = instr[15:12];
    d.s1    = instr[19:16];
    d.s2    = str ? instr[15:12] : instr[3:0];
    d.rn    = rd(d.s1);
    d.rm    = rd(d.s2);
    if (in_valid && cond_pass(instr[31:28], status)) begin
      if (mode == 2'd0) begin
        d.s = sb;
        case (op)
          4'd13: begin d.cmd = 4'd1; d.wb = 1; end
          4'd15: begin d.cmd = 4'd9; d.wb = 1; end
          4'd4:  begin d.cmd = 4'd2; d.wb = 1; end
          4'd5:  begin d.cmd = 4'd3; d.wb = 1; end
          4'd2:  begin d.cmd = 4'd4; d.wb = 1; end
          4'd6:  begin d.cmd = 4'd5; d.wb = 1; end
          4'd0:  begin d.cmd = 4'd6; d.wb = 1; end
          4'd12: begin d.cmd = 4'd7; d.wb = 1; end
          4'd1:  begin d.cmd = 4'd8; d.wb = 1; end
          4'd10: d.cmd = 4'd4;
          4'd8:  d.cmd = 4'd6;
          default: ;
        endcase
      end else if (mode == 2'd1) begin
        d.cmd = 4'd2;
        if (sb) begin d.mr = 1; d.wb = 1; end
        else d.mw = 1;
      end else if (mode == 2'd2) begin
        d.b = 1;
      end
    end
    hz = (in_valid && !((mode == 2'd0 && (op == 4'd13 || op == 4'd15)) || mode == 2'd2)
          && pend(d.s1)) ||
         (in_valid && ((mode == 2'd0 && !instr[25]) || str) && pend(d.s2));
    chk("hazard", hazard, hz);
    if (flush || (!stall && hz)) begin
      m_ex = d;
      m_ex.valid = 0; m_ex.wb = 0; m_ex.mr = 0; m_ex.mw = 0;
      m_ex.b = 0; m_ex.s = 0; m_ex.cmd = '0;
    end else if (!stall) begin
      m_ex = d;
    end
    if (wb_en) m_regs[wb_dest] = wb_value;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    in_valid = 0; instr = '0; pc_in = '0; status = '0;
    wb_en = 0; wb_dest = '0; wb_value = '0;
    exe_wb_en = 0; exe_dest = '0; mem_wb_en = 0; mem_dest = '0;
    stall = 0; flush = 0;
  endtask

  // Entered one time unit after a rising edge; leaves on a falling edge.
  task automatic async_reset_check();
    #1 rst = 0;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_ex_wb_en", ex_wb_en, 0);
    chk("arst_ex_exe_cmd", ex_exe_cmd, 0);
    chk("arst_ex_val_rn", ex_val_rn, 0);
    chk("arst_ex_pc", ex_pc, 0);
    chk("arst_ex_dest", ex_dest, 0);
    chk("arst_d2_valid", d2_valid, 0);
    chk("arst_d2_val_rn", d2_val_rn, 0);
    #1 rst = 1;
    foreach (m_regs[k]) m_regs[k] = '0;
    m_ex = '{default: 0};
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    idle();
    foreach (m_regs[k]) m_regs[k] = '0;
    m_ex = '{default: 0};

    // Reset state; hazard stays combinational during reset.
    instr = 32'hE0821003; in_valid = 1; exe_wb_en = 1; exe_dest = 4'd2;
    #12;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_wb_en", ex_wb_en, 0);
    chk("rst_ex_exe_cmd", ex_exe_cmd, 0);
    chk("rst_ex_val_rn", ex_val_rn, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_hazard", hazard, 1);
    idle();
    #1 rst = 1;

    // Preload R2=5, R3=7.
    wb_en = 1; wb_dest = 4'd2; wb_value = 32'd5; cycle();
    wb_dest = 4'd3; wb_value = 32'd7; cycle();

    // ADD R1,R2,R3
    idle(); instr = 32'hE0821003; in_valid = 1; pc_in = 32'h100;
    cycle();
    chk("t1_cmd", ex_exe_cmd, 4'b0010);
    chk("t1_wb", ex_wb_en, 1);
    chk("t1_rn", ex_val_rn, 32'd5);
    chk("t1_rm", ex_val_rm, 32'd7);
    chk("t1_dest", ex_dest, 4'd1);
    chk("t1_valid", ex_valid, 1);

    // ADDEQ with Z=0 then Z=1
    instr = 32'h00821003; status = 4'b0000;
    cycle();
    chk("t2_fail_valid", ex_valid, 1);
    chk("t2_fail_wb", ex_wb_en, 0);
    chk("t2_fail_cmd", ex_exe_cmd, 4'b0000);
    status = 4'b1000;
    cycle();
    chk("t2_pass_wb", ex_wb_en, 1);
    chk("t2_pass_cmd", ex_exe_cmd, 4'b0010);

    // Hazards
    status = 4'b0000; instr = 32'hE0821003; exe_wb_en = 1; exe_dest = 4'd2;
    #1 chk("t3_exe_hazard", hazard, 1);
    cycle();
    chk("t3_bubble_valid", ex_valid, 0);
    instr = 32'hE3A01004;
    #1 chk("t3_mov_imm_hazard", hazard, 0);
    cycle();
    chk("t3_mov_cmd", ex_exe_cmd, 4'b0001);
    exe_wb_en = 0; mem_wb_en = 1; mem_dest = 4'd2; instr = 32'hE0821003;
    #1;
    chk("t3_mem_hazard", hazard, 1);
    chk("t3_mem_hazard_disabled", d2_hazard, 0);
    cycle();

    // Write-through
    idle(); instr = 32'hE0821003; in_valid = 1;
    wb_en = 1; wb_dest = 4'd2; wb_value = 32'hDEADBEEF;
    cycle();
    chk("t4_wt_rn", ex_val_rn, 32'hDEADBEEF);
    chk("t4_rm", ex_val_rm, 32'd7);

    // Flush beats stall; stall holds; STR
    idle(); instr = 32'hE0821003; in_valid = 1; stall = 1; flush = 1;
    cycle();
    chk("t5_flush_valid", ex_valid, 0);
    chk("t5_flush_wb", ex_wb_en, 0);
    stall = 0; flush = 0;
    cycle();
    stall = 1; instr = 32'hE5854000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_hold_valid", ex_valid, 1);
      chk("t5_hold_cmd", ex_exe_cmd, 4'b0010);
      chk("t5_hold_rn", ex_val_rn, 32'hDEADBEEF);
      chk("t5_hold_dest", ex_dest, 4'd1);
    end
    stall = 0;
    cycle();
    chk("t5_str_mem_w", ex_mem_w_en, 1);
    chk("t5_str_src2", ex_src2, 4'd4);
    chk("t5_str_wb", ex_wb_en, 0);

    // Narrow instance: R7 write and read back
    idle(); wb_en = 1; wb_dest = 4'd7; wb_value = 32'h1234BEEF;
    cycle();
    idle(); instr = 32'hE0871003; in_valid = 1;
    cycle();
    chk("t6_d2_rn", d2_val_rn, 16'hBEEF);
    chk("t6_d2_rm", d2_val_rm, 16'h0007);
    chk("t6_d2_src1", d2_src1, 3'd7);
    chk("t6_d2_valid", d2_valid, 1);

    async_reset_check();

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      int r;
      instr = $urandom;
      r = $urandom_range(0, 9);
      instr[27:26] = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 2) == 0) instr[31:28] = 4'hE;
      in_valid  = ($urandom_range(0, 7) != 0);
      status    = $urandom;
      pc_in     = $urandom;
      wb_en     = $urandom_range(0, 1);
      wb_dest   = $urandom;
      wb_value  = $urandom;
      exe_wb_en = ($urandom_range(0, 2) == 0);
      exe_dest  = $urandom;
      mem_wb_en = ($urandom_range(0, 2) == 0);
      mem_dest  = $urandom;
      stall     = ($urandom_range(0, 6) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      cycle();
      if (t == 200) async_reset_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name:
id_stage_pipe

Overview:
Parametrised successor decode stage for the ARM pipeline. It contains the condition check, the control decode and a parametrised register file with write-through bypass. It adds RAW hazard detection against the EXE and MEM stages and a registered ID/EX pipeline boundary with valid, stall and flush. It sits between the IF/ID register and the EXE stage.

Parameters:
DATA_W, 32, datapath and register width
NUM_REGS, 16, register-file depth; register index = instruction nibble, ADDR_W = clog2(NUM_REGS)
HAZ_MEM_EN, 1, 1 = also compare against MEM-stage destination; 0 = EXE stage only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
pc_in  in  DATA_W  PC of the instruction in ID
instr_in  in  32  instruction in ID
in_valid  in  1  instruction in ID is real (not a bubble)
status  in  4  {Z,C,N,V} from the status register
wb_en / wb_dest / wb_value  in  1 / ADDR_W / DATA_W  writeback port
exe_wb_en / exe_dest  in  1 / ADDR_W  EXE-stage writer
mem_wb_en / mem_dest  in  1 / ADDR_W  MEM-stage writer
stall  in  1  hold ID/EX contents
flush  in  1  kill the ID/EX contents (taken branch)
hazard  out  1  combinational; freeze PC and IF/ID
ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm  out  1 each  registered controls; ex_imm = I bit
ex_exe_cmd  out  4  registered ALU command
ex_pc, ex_val_rn, ex_val_rm  out  DATA_W  registered
ex_shift_op  out  12  instr[11:0]
ex_imm24  out  24  instr[23:0]
ex_dest, ex_src1, ex_src2  out  ADDR_W  registered register indices

Behaviour:
- Reset (rst=0, asynchronous): all ex_* outputs = 0 and all registers = 0. Hazard logic still evaluates combinationally.
- Condition field instr[31:28]:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - 1110 and 1111 always pass.
- Decode, mode = instr[27:26], op = instr[24:21], S = instr[20]:
  - mode 00 ALU ops and commands:
    - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011
    - SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000
    - CMP 1010->0100, TST 1000->0110
  - mode 00 writeback and flags: wb_en=1 except CMP/TST; s=S; unknown op gives cmd 0000, wb 0.
  - mode 01: cmd 0010. S=1 is LDR (mem_r, wb_en); S=0 is STR (mem_w).
  - mode 10: b=1, all other controls 0.
- Register file:
  - NUM_REGS x DATA_W, written on the rising edge when wb_en=1.
  - Reads are combinational: src1 = instr[19:16]; src2 = instr[15:12] if STR else instr[3:0].
  - Write-through: if wb_en and wb_dest equals a read address, that read returns wb_value in the same cycle.
- Source use:
  - use1 = in_valid & !(MOV|MVN|branch).
  - use2 = in_valid & ((mode 00 & !I) | STR).
- Hazard: hazard = (use1 & match(src1)) | (use2 & match(src2)).
  - match(x) = (exe_wb_en & exe_dest==x) | (HAZ_MEM_EN & mem_wb_en & mem_dest==x).
- Gating: controls (wb, mem_r, mem_w, b, s, cmd) are forced to 0 when the condition fails or in_valid=0. ex_valid still follows in_valid; a failed condition becomes a valid no-op.
- ID/EX update priority per rising edge:
  1. flush: load a bubble (all controls 0, ex_valid 0).
  2. stall: hold all ex_*.
  3. hazard: load a bubble.
  4. Otherwise load the decoded values.
- Data fields (pc, vals, imm, indices) load in the bubble and normal cases; they are don't-care when ex_valid=0. Zeroing them is allowed.
- Latency: one cycle from ID inputs to ex_* outputs.
- Reset asserted mid-operation clears everything immediately, with no clock needed. After reset deasserts, the first rising edge loads normally.

Test Plan:
1. Reset, then ADD R1,R2,R3 (0xE0821003) with R2=5, R3=7 preloaded via WB, in_valid=1 -> next edge: ex_exe_cmd=0010, ex_wb_en=1, ex_val_rn=5, ex_val_rm=7, ex_dest=1, ex_valid=1.
2. Condition fail: status Z=0, ADDEQ (0x00821003) -> ex_valid=1, ex_wb_en=0, ex_exe_cmd=0000. Same with Z=1 -> ex_wb_en=1, ex_exe_cmd=0010.
3. Hazard: exe_wb_en=1, exe_dest=2, ADD R1,R2,R3 -> hazard=1, ex_valid=0 next edge. With MOV R1,#4 (0xE3A01004) and the same EXE state -> hazard=0. With HAZ_MEM_EN=0, mem_dest=2 -> hazard=0.
4. Write-through: wb_en=1, wb_dest=2, wb_value=0xDEADBEEF in the same cycle ADD reads R2 -> ex_val_rn=0xDEADBEEF.
5. Priority: stall=1, flush=1 together -> bubble loaded. stall=1 alone for 3 cycles -> ex_* unchanged. STR R4,[R5] (0xE5854000) -> ex_mem_w_en=1, ex_src2=4.
6. Parametrisation: DATA_W=16, NUM_REGS=8 -> writes to R7 read back, and ADDR_W=3 widths hold. Async reset pulse mid-stream -> all ex_* = 0 before the next edge.
